add_pipe: RTL

//  Parametrised pipelined ripple adder: WIDTH-bit A+B+CI split into STAGES equal

---
 rtl/add_pipe.sv | 110 +++++++++++
 1 files changed

// File: rtl/add_pipe.sv
// Pipelined ripple adder: WIDTH-bit A+B+CI split into STAGES slices, one slice per stage,
// with a valid/ready stream interface and global stall. Optional subtract via ADD_PIPE_SUB_EN.
module add_pipe #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
`ifdef ADD_PIPE_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             co
);

   localparam int SL = WIDTH / STAGES;

   logic [STAGES-1:0] r_vld;
   logic [STAGES-1:0] r_cy;
   logic [WIDTH-1:0]  r_sum [STAGES];
   logic [WIDTH-1:0]  r_a   [STAGES];
   logic [WIDTH-1:0]  r_b   [STAGES];

   logic              w_adv;
   logic [WIDTH-1:0]  w_bIn;
   logic              w_cIn;
   logic [WIDTH-1:0]  w_aSrc    [STAGES];
   logic [WIDTH-1:0]  w_bSrc    [STAGES];
   logic [WIDTH-1:0]  w_sSrc    [STAGES];
   logic [WIDTH-1:0]  w_sumNext [STAGES];
   logic [STAGES-1:0] w_cSrc;
   logic [STAGES-1:0] w_vSrc;
   logic [STAGES-1:0] w_cyNext;
   logic [SL:0]       w_slice   [STAGES];

   // Subtraction is folded in at the entry: inverted B plus a forced carry-in rides down the pipe.
`ifdef ADD_PIPE_SUB_EN
   always_comb begin
      w_bIn = sub ? ~b : b;
      w_cIn = sub ? 1'b1 : ci;
   end
`else
   always_comb begin
      w_bIn = b;
      w_cIn = ci;
   end
`endif

   always_comb begin
      w_adv     = !r_vld[STAGES-1] | out_ready;
      in_ready  = w_adv;
      out_valid = r_vld[STAGES-1];
      sum       = r_sum[STAGES-1];
      co        = r_cy[STAGES-1];
   end

   always_comb begin
      w_aSrc[0] = a;
      w_bSrc[0] = w_bIn;
      w_sSrc[0] = '0;
      w_cSrc[0] = w_cIn;
      w_vSrc[0] = in_valid;
      for (int k = 1; k < STAGES; k++) begin
         w_aSrc[k] = r_a[k-1];
         w_bSrc[k] = r_b[k-1];
         w_sSrc[k] = r_sum[k-1];
         w_cSrc[k] = r_cy[k-1];
         w_vSrc[k] = r_vld[k-1];
      end
   end

   // Stage k fills in sum slice k; lower slices are already final, upper ones come later.
   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         w_slice[k]   = {1'b0, w_aSrc[k][k*SL +: SL]} + {1'b0, w_bSrc[k][k*SL +: SL]}
                        + {{SL{1'b0}}, w_cSrc[k]};
         w_sumNext[k] = w_sSrc[k];
         w_sumNext[k][k*SL +: SL] = w_slice[k][SL-1:0];
         w_cyNext[k]  = w_slice[k][SL];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld <= '0;
         r_cy  <= '0;
         for (int k = 0; k < STAGES; k++) begin
            r_sum[k] <= '0;
            r_a[k]   <= '0;
            r_b[k]   <= '0;
         end
      end else if (w_adv) begin
         r_vld <= w_vSrc;
         r_cy  <= w_cyNext;
         for (int k = 0; k < STAGES; k++) begin
            r_sum[k] <= w_sumNext[k];
            r_a[k]   <= w_aSrc[k];
            r_b[k]   <= w_bSrc[k];
         end
      end
   end

endmodule
